// File: rtl/fifo_stream_adapter_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_stream_adapter_pkg;

    localparam int FIFO_RD_LATENCY    = 1;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_PKT_CNT_W  = 16;

    // Two slots cover the registered issue decision, plus one per cycle of read latency.
    localparam int SKID_DEPTH = 2 + FIFO_RD_LATENCY;

    function automatic int word_cnt_width(input int pkt_len);
        return ($clog2(pkt_len) > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_adapter_if.sv
// Valid/ready stream carrying framed words out of the adapter.
interface fifo_stream_adapter_if
    import fifo_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_valid, m_last, output m_ready);

endinterface

// File: rtl/fifo_stream_adapter_skid_buf3.sv
// Three-entry circular buffer; head_data is the oldest stored word.
module skid_buf3
    import fifo_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem_q [3];
    logic [DATA_WIDTH-1:0] mem_d [3];
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  do_push, do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        do_pop   = pop && (occ_q != 2'd0);
        // A push into a full buffer is only legal when the head leaves in the same cycle.
        do_push  = push && ((occ_q != 2'd3) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Pulls words from a registered-read FIFO into a skid buffer and streams them
// out as fixed-length packets, counting completed packets.
module fifo_stream_adapter
    import fifo_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PKT_LEN    = 8,
    parameter int PKT_CNT_W  = DEFAULT_PKT_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     fifo_empty,
    output logic                     fifo_rden,
    input  logic [DATA_WIDTH-1:0]    fifo_rddata,
    fifo_stream_adapter_if.master    m_if,
    output logic [PKT_CNT_W-1:0]     pkt_count
);

    localparam int             WCW      = word_cnt_width(PKT_LEN);
    localparam logic [WCW-1:0] LAST_IDX = WCW'(PKT_LEN - 1);

    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  inflight_q, inflight_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic [PKT_CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [2:0]            pending;
    logic                  m_valid, m_last, beat;

    skid_buf3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_rddata),
        .pop       (beat),
        .occ       (occ),
        .head_data (head_data)
    );

    // Stream handshake: a word moves when m_valid && m_ready; while m_valid is high
    // and m_ready low, m_data and m_last stay put because the head only advances on a beat.
    always_comb begin
        pending     = {1'b0, occ} + {2'b00, inflight_q};
        // Issue is decided from registered state only, so m_ready never reaches fifo_rden.
        fifo_rden   = !rst && en && !fifo_empty && (pending < 3'(SKID_DEPTH));
        inflight_d  = fifo_rden;
        m_valid     = (occ != 2'd0);
        m_last      = m_valid && (word_cnt_q == LAST_IDX);
        beat        = m_valid && m_if.m_ready;
        word_cnt_d  = word_cnt_q;
        pkt_count_d = pkt_count_q;
        if (beat) begin
            word_cnt_d = m_last ? '0 : word_cnt_q + WCW'(1);
            if (m_last) begin
                pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            word_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            word_cnt_q  <= word_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_if.m_data  = head_data;
    assign m_if.m_valid = m_valid;
    assign m_if.m_last  = m_last;
    assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter with a behavioural one-cycle-latency FIFO.
module tb_fifo_stream_adapter;
    import fifo_stream_adapter_pkg::*;

    localparam int DW  = 32;
    localparam int PL  = 8;
    localparam int PCW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           fifo_empty;
    logic           fifo_rden;
    logic [DW-1:0]  fifo_rddata;
    logic [PCW-1:0] pkt_count;

    fifo_stream_adapter_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_stream_adapter #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL),
        .PKT_CNT_W  (PCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_rden   (fifo_rden),
        .fifo_rddata (fifo_rddata),
        .m_if        (s_if.master),
        .pkt_count   (pkt_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic rdy;
        logic en;
        logic exp_rden;
        logic exp_valid;
        logic hold0;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];

    int checks = 0;
    int failures = 0;
    int cyc, rden_cnt, beat_cnt, first_rden, first_valid, last_beat_cyc, first_last_beat, load_pos;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        rden_cnt = 0;
        beat_cnt = 0;
        first_rden = -1;
        first_valid = -1;
        last_beat_cyc = -1;
        first_last_beat = -1;
    endtask

    task automatic add_vec(input int n, input logic rdy, input logic e, input logic rd,
                           input logic v, input logic h);
        vec_t t;
        t = '{rdy: rdy, en: e, exp_rden: rd, exp_valid: v, hold0: h};
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    // driver: words go into the FIFO model and, in order, into the scoreboard
    task automatic load_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
            exp_last_q.push_back(load_pos == PL - 1);
            load_pos = (load_pos == PL - 1) ? 0 : load_pos + 1;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // Commit the current cycle (count reads, score beats), cross one clock edge,
    // emulate the FIFO read port, then apply the inputs for the new cycle.
    task automatic step(input logic rdy, input logic e);
        logic          rden_now;
        logic [DW-1:0] ed;
        logic          el;
        #1;
        rden_now = fifo_rden;
        if (rden_now) begin
            rden_cnt++;
            if (first_rden < 0) first_rden = cyc;
        end
        if (s_if.m_valid && first_valid < 0) first_valid = cyc;
        if (s_if.m_valid && s_if.m_ready) begin
            beat_cnt++;
            last_beat_cyc = cyc;
            if (s_if.m_last && first_last_beat < 0) first_last_beat = beat_cnt;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", s_if.m_data);
            end else begin
                ed = exp_q.pop_front();
                el = exp_last_q.pop_front();
                check("beat_data", s_if.m_data, ed);
                check("beat_last", s_if.m_last, el);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rden_now) begin
            if (fifo_q.size() > 0) fifo_rddata = fifo_q.pop_front();
            else begin
                checks++;
                failures++;
                $display("FAIL fifo_underflow: got rden with 0 words expected none");
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        s_if.m_ready = rdy;
        en = e;
        #1;
    endtask

    task automatic run_beats(input string name, input int n, input int budget);
        int b = 0;
        while (beat_cnt < n && b < budget) begin
            step(1'b1, en);
            b++;
        end
        check(name, beat_cnt, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_rden", fifo_rden, 0);
        check("reset_valid", s_if.m_valid, 0);
        check("reset_last", s_if.m_last, 0);
        check("reset_data", s_if.m_data, 0);
        check("reset_pkt_count", pkt_count, 0);
        fifo_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        load_pos = 0;
        fifo_rddata = '0;
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_stats();
    endtask

    initial begin
        int   bp_rden;
        logic gap_valid;
        vec_t v;

        rst = 1'b1;
        en = 1'b1;
        s_if.m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rddata = '0;
        load_pos = 0;
        clear_stats();

        // backpressure cycle table: cycle 0 is the cycle the words become visible
        add_vec(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        add_vec(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        add_vec(9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        add_vec(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add_vec(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        do_reset();

        // streaming: 16 words, two packets
        load_words(16, 32'd0);
        s_if.m_ready = 1'b1;
        run_beats("stream_beats", 16, 40);
        check("stream_first_rden_cyc", first_rden, 0);
        check("stream_latency", first_valid - first_rden, 2);
        check("stream_back_to_back", last_beat_cyc - first_valid, 15);
        check("stream_rden_cnt", rden_cnt, 16);
        check("stream_pkt_count", pkt_count, 2);
        check("stream_sb_empty", exp_q.size(), 0);

        // reset in the middle of a packet, then a fresh packet
        clear_stats();
        load_words(20, 32'h1000);
        run_beats("rstmid_pre_beats", 5, 20);
        do_reset();
        load_words(8, 32'h2000);
        s_if.m_ready = 1'b1;
        run_beats("rstmid_beats", 8, 30);
        check("rstmid_last_idx", first_last_beat, 8);
        check("rstmid_pkt_count", pkt_count, 1);
        check("rstmid_sb_empty", exp_q.size(), 0);

        // backpressure from idle, then release
        do_reset();
        load_words(10, 32'd0);
        bp_rden = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (i == 0) begin
                s_if.m_ready = v.rdy;
                en = v.en;
                #1;
            end else begin
                step(v.rdy, v.en);
            end
            if (i == 12) bp_rden = rden_cnt;
            check($sformatf("bp_rden[%0d]", i), fifo_rden, v.exp_rden);
            check($sformatf("bp_valid[%0d]", i), s_if.m_valid, v.exp_valid);
            if (v.hold0) check($sformatf("bp_hold[%0d]", i), s_if.m_data, 0);
        end
        check("bp_rden_while_stalled", bp_rden, 3);
        check("bp_rden_total", rden_cnt, 10);
        check("bp_beats", beat_cnt, 10);
        check("bp_sb_empty", exp_q.size(), 0);

        // gap: 5 words, 6 empty cycles, 3 more words
        do_reset();
        en = 1'b1;
        s_if.m_ready = 1'b1;
        load_words(5, 32'h300);
        run_beats("gap_first_beats", 5, 20);
        gap_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            gap_valid = gap_valid | s_if.m_valid;
        end
        check("gap_valid_low", gap_valid, 0);
        check("gap_no_reads", rden_cnt, 5);
        check("gap_pkt_count_mid", pkt_count, 0);
        load_words(3, 32'h308);
        run_beats("gap_total_beats", 8, 20);
        check("gap_last_idx", first_last_beat, 8);
        check("gap_pkt_count", pkt_count, 1);
        check("gap_sb_empty", exp_q.size(), 0);

        // enable drops with two words buffered and one read in flight
        do_reset();
        en = 1'b1;
        s_if.m_ready = 1'b0;
        load_words(6, 32'h400);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("en_low_rden", fifo_rden, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("en_rden_cnt", rden_cnt, 3);
        check("en_drain_beats", beat_cnt, 3);
        check("en_valid_after_drain", s_if.m_valid, 0);
        en = 1'b1;
        run_beats("en_resume_beats", 6, 20);
        check("en_pkt_count", pkt_count, 0);
        check("en_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
